period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 133 +++++++++++++
 tb/tb_period_meter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: counts clk cycles between rising edges of tick_in and holds the
// result until acknowledged. Define PERIOD_METER_SYNC_EN to add a 2-flop tick_in synchronizer.
module period_meter #(
    parameter int  MAX_COUNT = 255,
    localparam int W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         tick_in,
    input  logic         ack,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         overflow,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [W-1:0] CNT_MAX = W'(MAX_COUNT);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         prev_q, prev_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         ovr_q, ovr_d;

    logic samp, rise, accept;
    logic cnt_load, cnt_inc, capture;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], tick_in};
    end

    assign samp = sync_q[1];
`else
    assign samp = tick_in;
`endif

    // Edge history is held at 0 while disabled, so a high level on re-enable counts as an edge.
    assign rise   = enable & samp & ~prev_q;
    assign prev_d = enable & samp;
    assign accept = ack & valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // An edge on the first enabled cycle arms directly instead of being lost.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = rise ? MEASURE : ARM;
                ARM:     if (rise) state_d = MEASURE;
                MEASURE: state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        capture  = 1'b0;
        if (enable) begin
            cnt_load = rise;
            if (state_q == MEASURE) begin
                capture = rise;
                cnt_inc = ~rise;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!enable)                          cnt_d = '0;
        else if (cnt_load)                    cnt_d = CNT_ONE;
        else if (cnt_inc && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end

    // A capture that meets a pending, unacked result is dropped and flagged.
    always_comb begin
        period_d = period_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        ovr_d    = ovr_q;
        if (capture && (!valid_q || accept)) begin
            period_d = cnt_q;
            ovf_d    = (cnt_q == CNT_MAX);
            valid_d  = 1'b1;
        end else if (capture) begin
            ovr_d    = 1'b1;
        end else if (accept) begin
            valid_d  = 1'b0;
            ovr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (MAX_COUNT 255 and 15) share directed and random
// stimulus and are checked every cycle against an interval-based model.
module tb_period_meter;

`ifdef PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, tick_in = 1'b0, ack = 1'b0;
    logic [7:0] p255;
    logic       v255, of255, or255;
    logic [3:0] p15;
    logic       v15, of15, or15;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    period_meter #(.MAX_COUNT(255)) u255 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick_in), .ack(ack),
        .period(p255), .valid(v255), .overflow(of255), .overrun(or255)
    );

    period_meter #(.MAX_COUNT(15)) u15 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick_in), .ack(ack),
        .period(p15), .valid(v15), .overflow(of15), .overrun(or15)
    );

    // Model: remember the cycle of the last accepted edge; a result is the elapsed cycle count, clamped.
    bit h1, h2, prev, armed;
    int last;
    int mmax [2] = '{255, 15};
    bit mv [2];
    int mp [2];
    bit mo [2];
    bit mr [2];

    always @(posedge clk) begin
        bit samp, rise, cap, acc;
        int iv;
        cyc++;
        if (!reset_n) begin
            h1 = 0; h2 = 0; prev = 0; armed = 0; last = 0;
            for (int i = 0; i < 2; i++) begin
                mv[i] = 0; mp[i] = 0; mo[i] = 0; mr[i] = 0;
            end
        end else begin
            samp = (LAT == 2) ? h2 : tick_in;
            rise = enable && samp && !prev;
            cap  = rise && armed;
            iv   = cyc - last;
            for (int i = 0; i < 2; i++) begin
                acc = ack && mv[i];
                if (cap && (!mv[i] || acc)) begin
                    mp[i] = (iv < mmax[i]) ? iv : mmax[i];
                    mo[i] = (iv >= mmax[i]);
                    mv[i] = 1;
                end else if (cap) begin
                    mr[i] = 1;
                end else if (acc) begin
                    mv[i] = 0;
                    mr[i] = 0;
                end
            end
            if (!enable)   armed = 0;
            else if (rise) begin armed = 1; last = cyc; end
            prev = enable && samp;
            h2 = h1;
            h1 = tick_in;
        end
    end

    always @(posedge clk) begin
        #2;
        n_tests++;
        if ({v255, of255, or255} !== {mv[0], mo[0], mr[0]} || int'(p255) != mp[0]) begin
            n_fail++;
            $display("FAIL u255_cycle cyc=%0d got v=%b p=%0d ovf=%b ovr=%b, want v=%b p=%0d ovf=%b ovr=%b",
                     cyc, v255, p255, of255, or255, mv[0], mp[0], mo[0], mr[0]);
        end
        n_tests++;
        if ({v15, of15, or15} !== {mv[1], mo[1], mr[1]} || int'(p15) != mp[1]) begin
            n_fail++;
            $display("FAIL u15_cycle cyc=%0d got v=%b p=%0d ovf=%b ovr=%b, want v=%b p=%0d ovf=%b ovr=%b",
                     cyc, v15, p15, of15, or15, mv[1], mp[1], mo[1], mr[1]);
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic cyc_drive(input bit t, input bit a);
        tick_in = t;
        ack     = a;
        @(negedge clk);
    endtask

    task automatic ticks(input int gap, input int n, input bit a);
        for (int k = 0; k < n; k++) begin
            cyc_drive(1'b1, a);
            repeat (gap - 1) cyc_drive(1'b0, a);
        end
    endtask

    initial begin
        int gap, style;
        bit t;

        repeat (3) @(negedge clk);
        lit("rst_valid", int'(v255), 0);
        lit("rst_period", int'(p255), 0);
        lit("rst_ovf", int'(of255), 0);
        lit("rst_ovr", int'(or255), 0);
        reset_n = 1'b1;
        cyc_drive(1'b0, 1'b0);

        // nominal: ticks every 10, first edge only arms
        enable = 1'b1;
        repeat (2) cyc_drive(1'b0, 1'b0);
        ticks(10, 1, 1'b0);
        lit("nom_first_edge_no_result", int'(v255), 0);
        ticks(10, 4, 1'b1);
        ticks(10, 1, 1'b0);
        lit("nom_valid", int'(v255), 1);
        lit("nom_period", int'(p255), 10);
        lit("nom_ovf", int'(of255), 0);
        lit("nom_period_u15", int'(p15), 10);
        lit("model_nom_period", mp[0], 10);

        // overflow: 40-cycle interval saturates MAX_COUNT=15, then 7-cycle interval
        ticks(40, 3, 1'b1);
        ticks(40, 1, 1'b0);
        lit("ovf_period_u15", int'(p15), 15);
        lit("ovf_flag_u15", int'(of15), 1);
        lit("ovf_period_u255", int'(p255), 40);
        lit("ovf_flag_u255", int'(of255), 0);
        lit("model_ovf_period_u15", mp[1], 15);
        cyc_drive(1'b0, 1'b1);
        ticks(7, 3, 1'b1);
        ticks(7, 1, 1'b0);
        lit("p7_period_u15", int'(p15), 7);
        lit("p7_ovf_u15", int'(of15), 0);
        lit("p7_period_u255", int'(p255), 7);

        // overrun: results every 5 with ack withheld
        ticks(5, 2, 1'b1);
        ticks(5, 3, 1'b0);
        lit("ovr_valid", int'(v255), 1);
        lit("ovr_period", int'(p255), 5);
        lit("ovr_flag", int'(or255), 1);
        lit("ovr_flag_u15", int'(or15), 1);
        cyc_drive(1'b1, 1'b0);
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, 1'b1);
        lit("ovr_ack_valid", int'(v255), 0);
        lit("ovr_ack_flag", int'(or255), 0);
        cyc_drive(1'b0, 1'b0);
        ticks(5, 1, 1'b0);
        lit("ovr_next_period", int'(p255), 5);
        lit("ovr_next_valid", int'(v255), 1);
        lit("ovr_next_flag", int'(or255), 0);

        // ack on the exact capture cycle
        repeat (4) cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b1, LAT == 0);
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, LAT == 2);
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, 1'b0);
        lit("coinc_valid", int'(v255), 1);
        lit("coinc_period", int'(p255), 9);
        lit("coinc_ovr", int'(or255), 0);

        // enable dropped 4 cycles into an interval
        cyc_drive(1'b0, 1'b1);
        ticks(10, 2, 1'b1);
        cyc_drive(1'b1, 1'b1);
        repeat (3) cyc_drive(1'b0, 1'b1);
        enable = 1'b0;
        repeat (6) cyc_drive(1'b0, 1'b1);
        enable = 1'b1;
        ticks(10, 1, 1'b0);
        ticks(10, 2, 1'b0);
        lit("dis_period", int'(p255), 10);
        lit("dis_valid", int'(v255), 1);
        lit("dis_period_u15", int'(p15), 10);

        // reset pulsed 4 cycles into an interval
        cyc_drive(1'b0, 1'b1);
        ticks(10, 2, 1'b1);
        cyc_drive(1'b1, 1'b1);
        repeat (3) cyc_drive(1'b0, 1'b1);
        reset_n = 1'b0;
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, 1'b0);
        lit("rst2_valid", int'(v255), 0);
        lit("rst2_period", int'(p255), 0);
        lit("rst2_ovr", int'(or255), 0);
        lit("rst2_period_u15", int'(p15), 0);
        reset_n = 1'b1;
        ticks(10, 1, 1'b0);
        ticks(10, 1, 1'b0);
        lit("rst2_first_period", int'(p255), 10);
        lit("rst2_first_valid", int'(v255), 1);
        lit("rst2_first_ovf", int'(of255), 0);

        // random phase: pulses, random bits and level waveforms, random ack/enable/reset
        for (int seg = 0; seg < 30; seg++) begin
            gap   = $urandom_range(1, 24);
            style = $urandom_range(0, 2);
            for (int k = 0; k < 100; k++) begin
                case (style)
                    0:       t = (k % gap) == 0;
                    1:       t = $urandom_range(0, 3) == 0;
                    default: t = ((k / gap) % 2) == 1;
                endcase
                enable  = ($urandom_range(0, 49) != 0);
                reset_n = ($urandom_range(0, 299) != 0);
                cyc_drive(t, $urandom_range(0, 2) == 0);
            end
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (4) cyc_drive(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
